// File: rtl/cpu_csr_pkg.sv
// Shared definitions for the Zicsr execution unit: funct3 codes, FSM
// state encoding, well-known CSR addresses and the read-only space test.
package cpu_csr_pkg;

   localparam logic [2:0] CSR_RW  = 3'b001;
   localparam logic [2:0] CSR_RS  = 3'b010;
   localparam logic [2:0] CSR_RC  = 3'b011;
   localparam logic [2:0] CSR_RWI = 3'b101;
   localparam logic [2:0] CSR_RSI = 3'b110;
   localparam logic [2:0] CSR_RCI = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } csr_state_e;

   localparam logic [11:0] CSR_CYCLE    = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
   localparam logic [11:0] CSR_TIME     = 12'hC01;
   localparam logic [11:0] CSR_TIMEH    = 12'hC81;
   localparam logic [11:0] CSR_INSTRET  = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH = 12'hC82;
   localparam logic [11:0] CSR_SSTATUS  = 12'h100;
   localparam logic [11:0] CSR_SIE      = 12'h104;
   localparam logic [11:0] CSR_STVEC    = 12'h105;
   localparam logic [11:0] CSR_SSCRATCH = 12'h140;
   localparam logic [11:0] CSR_SEPC     = 12'h141;
   localparam logic [11:0] CSR_SCAUSE   = 12'h142;
   localparam logic [11:0] CSR_STVAL    = 12'h143;
   localparam logic [11:0] CSR_SIP      = 12'h144;

   // Address bits [11:10] == 2'b11 mark the read-only CSR space.
   function automatic logic csr_is_read_only(input logic [11:0] addr);
      return (addr[11:10] == 2'b11);
   endfunction

endpackage

// File: rtl/cpu_csr_alu.sv
// Combinational new-value and write-enable computation for one Zicsr op.
module cpu_csr_alu
   import cpu_csr_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] old_val,
   input  logic [31:0] rs1_val,
   input  logic [4:0]  rs1_field,
   output logic [31:0] new_val,
   output logic        we
);

   logic [31:0] src;

   always_comb begin
      src     = funct3[2] ? {27'b0, rs1_field} : rs1_val;
      new_val = src;
      we      = (rs1_field != 5'd0);
      case (funct3[1:0])
         CSR_RW[1:0]: begin
            new_val = src;
            we      = 1'b1;
         end
         CSR_RS[1:0]: new_val = old_val | src;
         CSR_RC[1:0]: new_val = old_val & ~src;
         default:     new_val = src;
      endcase
   end

endmodule

// File: rtl/cpu_csr_unit.sv
// Zicsr read-modify-write sequencer: IDLE -> READ -> WRITE -> DONE, driving
// the CSR file bus as initiator. All outputs come straight from flops.
module cpu_csr_unit
   import cpu_csr_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [11:0] csr_addr,
   input  logic [4:0]  rs1_field,
   input  logic [31:0] rs1_val,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic [31:0] rd_val,
   output logic [11:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        bus_wr,
   input  logic [31:0] bus_rdata
);

   csr_state_e  state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [11:0] addr_q, addr_d;
   logic [4:0]  field_q, field_d;
   logic [31:0] src_q, src_d;
   logic [31:0] old_q, old_d;
   logic [31:0] new_q, new_d;
   logic        wr_en_q, wr_en_d;
   logic        fault_q, fault_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        illegal_q, illegal_d;
   logic [31:0] rd_val_q, rd_val_d;
   logic [11:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic        bus_wr_q, bus_wr_d;

   logic [31:0] alu_new;
   logic        alu_we;

   // The ALU sees the live read data so old/new/we are captured together
   // at the end of READ.
   cpu_csr_alu u_alu (
      .funct3    (funct3_q),
      .old_val   (bus_rdata),
      .rs1_val   (src_q),
      .rs1_field (field_q),
      .new_val   (alu_new),
      .we        (alu_we)
   );

   always_comb begin
      state_d   = state_q;
      funct3_d  = funct3_q;
      addr_d    = addr_q;
      field_d   = field_q;
      src_d     = src_q;
      old_d     = old_q;
      new_d     = new_q;
      wr_en_d   = wr_en_q;
      fault_d   = fault_q;
      illegal_d = illegal_q;
      rd_val_d  = rd_val_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               funct3_d = funct3;
               addr_d   = csr_addr;
               field_d  = rs1_field;
               src_d    = rs1_val;
               state_d  = ST_READ;
            end
         end
         ST_READ: begin
            old_d   = bus_rdata;
            new_d   = alu_new;
            fault_d = (funct3_q[1:0] == 2'b00) ||
                      (alu_we && csr_is_read_only(addr_q));
            wr_en_d = alu_we && !fault_d;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            illegal_d = fault_q;
            rd_val_d  = fault_q ? 32'd0 : old_q;
            state_d   = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are precomputed from the next state so they land on flops.
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      bus_addr_d  = (state_d == ST_READ || state_d == ST_WRITE) ? addr_d : 12'd0;
      bus_wr_d    = (state_d == ST_WRITE) && wr_en_d;
      bus_wdata_d = bus_wr_d ? new_d : 32'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         funct3_q    <= 3'd0;
         addr_q      <= 12'd0;
         field_q     <= 5'd0;
         src_q       <= 32'd0;
         old_q       <= 32'd0;
         new_q       <= 32'd0;
         wr_en_q     <= 1'b0;
         fault_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         illegal_q   <= 1'b0;
         rd_val_q    <= 32'd0;
         bus_addr_q  <= 12'd0;
         bus_wdata_q <= 32'd0;
         bus_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         field_q     <= field_d;
         src_q       <= src_d;
         old_q       <= old_d;
         new_q       <= new_d;
         wr_en_q     <= wr_en_d;
         fault_q     <= fault_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         illegal_q   <= illegal_d;
         rd_val_q    <= rd_val_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wr_q    <= bus_wr_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign illegal   = illegal_q;
   assign rd_val    = rd_val_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_wr    = bus_wr_q;

endmodule

// File: tb/tb_cpu_csr_unit.sv
// Bench for cpu_csr_unit: behavioural CSR file plus cycle counter, directed
// cases followed by random Zicsr ops checked against a reference model.
module tb_cpu_csr_unit;
   import cpu_csr_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [11:0] csr_addr;
   logic [4:0]  rs1_field;
   logic [31:0] rs1_val;
   logic        busy, done, illegal, bus_wr;
   logic [31:0] rd_val, bus_wdata, bus_rdata;
   logic [11:0] bus_addr;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] csr_mem [0:4095] = '{default: 32'h0};
   logic [31:0] ref_mem [0:4095] = '{default: 32'h0};
   logic [31:0] cyc_cnt = 32'h0000_1000;

   always #5 clk = ~clk;

   cpu_csr_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .funct3    (funct3),
      .csr_addr  (csr_addr),
      .rs1_field (rs1_field),
      .rs1_val   (rs1_val),
      .busy      (busy),
      .done      (done),
      .illegal   (illegal),
      .rd_val    (rd_val),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_wr    (bus_wr),
      .bus_rdata (bus_rdata)
   );

   // CSR file environment: cycle counter at 0xC00, plain storage elsewhere.
   assign bus_rdata = (bus_addr == CSR_CYCLE) ? cyc_cnt : csr_mem[bus_addr];

   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (bus_wr) csr_mem[bus_addr] <= bus_wdata;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Architectural meaning of one Zicsr instruction.
   function automatic void ref_model(input logic [2:0] f3, input logic [11:0] addr,
                                     input logic [4:0] fld, input logic [31:0] val,
                                     input logic [31:0] old, output logic [31:0] nv,
                                     output bit wr, output bit ill);
      logic [31:0] operand;
      bit writes;
      operand = (f3 >= 3'd4) ? 32'(fld) : val;
      if (f3 == 3'd1 || f3 == 3'd5)      nv = operand;
      else if (f3 == 3'd2 || f3 == 3'd6) nv = old | operand;
      else if (f3 == 3'd3 || f3 == 3'd7) nv = old & ~operand;
      else                                nv = 32'h0;
      writes = (f3 == 3'd1 || f3 == 3'd5) || (fld != 5'd0);
      ill    = (f3 == 3'd0 || f3 == 3'd4) || (writes && addr >= 12'hC00);
      wr     = writes && !ill;
   endfunction

   task automatic do_op(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] fld,
                        input logic [31:0] val, input bit noise);
      logic [31:0] old, exp_new, snap;
      bit exp_wr, exp_ill;
      @(negedge clk);
      start = 1'b1; funct3 = f3; csr_addr = addr; rs1_field = fld; rs1_val = val;
      @(posedge clk);
      #1;
      start = 1'b0;
      snap  = cyc_cnt;
      old   = (addr == CSR_CYCLE) ? snap : ref_mem[addr];
      ref_model(f3, addr, fld, val, old, exp_new, exp_wr, exp_ill);

      @(negedge clk);
      check_val("c1_busy", 32'(busy), 32'd1);
      check_val("c1_wr", 32'(bus_wr), 32'd0);
      check_val("c1_addr", 32'(bus_addr), 32'(addr));
      check_val("c1_done", 32'(done), 32'd0);
      if (noise) begin
         start = 1'b1; funct3 = CSR_RW; csr_addr = 12'($urandom);
         rs1_field = 5'($urandom); rs1_val = $urandom;
      end

      @(negedge clk);
      check_val("c2_wr", 32'(bus_wr), 32'(exp_wr));
      check_val("c2_wdata", bus_wdata, exp_wr ? exp_new : 32'h0);
      check_val("c2_addr", 32'(bus_addr), 32'(addr));
      check_val("c2_done", 32'(done), 32'd0);
      if (noise) begin
         start = 1'b1; rs1_val = $urandom; rs1_field = 5'($urandom);
      end

      @(negedge clk);
      start = 1'b0;
      check_val("c3_done", 32'(done), 32'd1);
      check_val("c3_illegal", 32'(illegal), 32'(exp_ill));
      check_val("c3_rd_val", rd_val, exp_ill ? 32'h0 : old);
      check_val("c3_wr", 32'(bus_wr), 32'd0);
      check_val("c3_addr", 32'(bus_addr), 32'd0);
      if (exp_wr) ref_mem[addr] = exp_new;

      @(negedge clk);
      check_val("c4_done", 32'(done), 32'd0);
      check_val("c4_busy", 32'(busy), 32'd0);
      check_val("c4_rd_hold", rd_val, exp_ill ? 32'h0 : old);
      check_val("c4_csr", csr_mem[addr], ref_mem[addr]);
      $display("op f3=%0d addr=%03h fld=%0d val=%08h -> rd=%08h ill=%0d wr=%0d",
               f3, addr, fld, val, rd_val, illegal, exp_wr);
   endtask

   logic [11:0] addr_list [0:7] = '{CSR_CYCLE, CSR_TIME, CSR_CYCLEH, CSR_SSTATUS,
                                    CSR_STVEC, CSR_SSCRATCH, CSR_SEPC, CSR_SCAUSE};

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; funct3 = 3'd0; csr_addr = 12'd0;
      rs1_field = 5'd0; rs1_val = 32'd0;
      #1;
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_illegal", 32'(illegal), 32'd0);
      check_val("rst_rd_val", rd_val, 32'd0);
      check_val("rst_addr", 32'(bus_addr), 32'd0);
      check_val("rst_wdata", bus_wdata, 32'd0);
      check_val("rst_wr", 32'(bus_wr), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases.
      do_op(CSR_RW, CSR_STVEC, 5'd3, 32'h8000_0100, 1'b0);
      check_val("stvec_after", csr_mem[CSR_STVEC], 32'h8000_0100);
      do_op(CSR_RW, CSR_SSCRATCH, 5'd2, 32'h0000_00F0, 1'b0);
      do_op(CSR_RS, CSR_SSCRATCH, 5'd1, 32'h0000_000F, 1'b0);
      check_val("sscratch_rs", csr_mem[CSR_SSCRATCH], 32'h0000_00FF);
      do_op(CSR_RC, CSR_SSCRATCH, 5'd1, 32'h0000_00F0, 1'b0);
      check_val("sscratch_rc", csr_mem[CSR_SSCRATCH], 32'h0000_000F);
      do_op(CSR_RSI, CSR_CYCLE, 5'd0, 32'hFFFF_FFFF, 1'b0);
      do_op(CSR_RSI, CSR_CYCLE, 5'd1, 32'h0, 1'b0);
      do_op(3'b000, CSR_SEPC, 5'd4, 32'h1234_5678, 1'b0);
      do_op(3'b100, CSR_SEPC, 5'd4, 32'h1234_5678, 1'b0);
      do_op(CSR_RW, CSR_SEPC, 5'd7, 32'hCAFE_0001, 1'b1);
      check_val("sepc_noise", csr_mem[CSR_SEPC], 32'hCAFE_0001);

      // Reset while the write cycle is on the bus.
      @(negedge clk);
      start = 1'b1; funct3 = CSR_RW; csr_addr = CSR_SSCRATCH;
      rs1_field = 5'd1; rs1_val = 32'hDEAD_BEEF;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("mrst_wr", 32'(bus_wr), 32'd0);
      check_val("mrst_wdata", bus_wdata, 32'd0);
      check_val("mrst_addr", 32'(bus_addr), 32'd0);
      check_val("mrst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("mrst_no_done", 32'(done), 32'd0);
      end
      check_val("mrst_no_write", csr_mem[CSR_SSCRATCH], ref_mem[CSR_SSCRATCH]);
      do_op(CSR_RS, CSR_SSCRATCH, 5'd9, 32'h0000_0F00, 1'b0);

      // Random ops.
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  f3;
         logic [11:0] a;
         logic [4:0]  fld;
         f3  = 3'($urandom_range(0, 7));
         a   = addr_list[$urandom_range(0, 7)];
         fld = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         do_op(f3, a, fld, $urandom, ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
